param_loader: RTL

PARAM_LOADER -- requirements
Module: param_loader

---
 rtl/param_loader.sv | 106 ++++++++++
 1 files changed

// File: rtl/param_loader.sv
// Sequential parameter loader: after Start, each Valid word is written into the next channel
// register until all N_CH channels are filled. Abort cancels the load and keeps written channels.
module param_loader #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int IW   = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Valid,
    input  logic [W-1:0]      Data_In,
    input  logic              Abort,
    output logic [N_CH-1:0]   Select,
    output logic [IW-1:0]     Index,
    output logic              Loaded,
    output logic              Busy,
    output logic [N_CH*W-1:0] Bank
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    localparam logic [IW-1:0] LastIdx = IW'(N_CH - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     index_q, index_d;
    logic [N_CH*W-1:0] bank_q, bank_d;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        bank_d  = bank_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StLoad;
                    index_d = '0;
                end
            end
            StLoad: begin
                // Abort wins over Valid: no write on the aborting cycle.
                if (Abort) begin
                    state_d = StIdle;
                    index_d = '0;
                end else if (Valid) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (index_q == IW'(k)) begin
                            bank_d[k*W +: W] = Data_In;
                        end
                    end
                    if (index_q == LastIdx) begin
                        state_d = StDone;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (Start) begin
                    state_d = StLoad;
                    index_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= StIdle;
            index_q <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            bank_q  <= bank_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        Select = '0;
        if (state_q == StLoad) begin
            for (int k = 0; k < N_CH; k++) begin
                Select[k] = (index_q == IW'(k));
            end
        end
    end

    assign Index  = index_q;
    assign Busy   = (state_q == StLoad);
    assign Loaded = (state_q == StDone);
    assign Bank   = bank_q;

    a_select_onehot0 : assert property (@(posedge Clock) $onehot0(Select));
    a_index_in_range : assert property (@(posedge Clock) index_q <= LastIdx);

endmodule
